div_iter: RTL
=============

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset; these are the only clock and reset in the block.
REQ-002 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-003 SHALL have port clock, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port ctrl_div, input, 1 bit: start pulse; operands are captured on the edge where it is high.
REQ-006 SHALL have port data_operandA, input, WIDTH bits: signed dividend.
REQ-007 SHALL have port data_operandB, input, WIDTH bits: signed divisor.
REQ-008 SHALL have port data_result, output, WIDTH bits: signed quotient.
REQ-009 SHALL have port data_exception, output, 1 bit: divide-by-zero flag.
REQ-010 SHALL have port data_resultRDY, output, 1 bit: one-cycle pulse marking a valid result.

Function
REQ-011 SHALL implement FSM states IDLE, DIV and FIX.
- IDLE -> DIV on ctrl_div=1 with a nonzero divisor.
- DIV -> FIX once the iteration counter reaches WIDTH.
- FIX -> IDLE unconditionally.
REQ-012 SHALL, on a start edge (cycle C), latch the operands, record sign = A[31] xor B[31], and convert both operands to magnitude (bitwise invert plus 1 when negative).
REQ-013 SHALL perform restoring division at one quotient bit per cycle in DIV, using a 6-bit counter and a (WIDTH+1)-bit partial remainder, over cycles C+1..C+32.
REQ-014 SHALL, in FIX, negate the quotient when sign=1; quotient truncates toward zero and the remainder is discarded.
REQ-015 SHALL drive data_result and data_resultRDY=1 in cycle C+33 (latency 33 cycles); RDY is high for exactly one cycle.
REQ-016 SHALL treat divisor==0 as divide-by-zero: data_exception=1, data_result=0 and data_resultRDY=1 in cycle C+1, with the FSM remaining in IDLE.
REQ-017 SHALL return 0x80000000 with data_exception=0 for 0x80000000 / 0xFFFFFFFF (two's-complement wrap).
REQ-018 SHALL correctly handle A=0x80000000 as an operand; its magnitude is 2^31 as an unsigned value.
REQ-019 SHALL treat ctrl_div=1 while in DIV or FIX as an abort-and-restart: new operands are captured, the counter is cleared, no RDY is issued for the aborted operation, and the new result follows at +33.
REQ-020 SHALL hold data_result and data_exception stable from the RDY cycle until the next start edge; data_exception is cleared on the next start.
REQ-021 SHALL give ctrl_div priority over the FIX->IDLE transition when both occur in the same cycle.

Reset
REQ-022 SHALL, when reset_n=0, immediately force: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0 and internal registers=0.
REQ-023 SHALL abandon any in-flight division on reset, with no RDY after release; the first start edge after reset behaves per REQ-012.
REQ-024 SHALL use a synchronous path for reset release; only assertion is asynchronous.

Structure
REQ-025 SHALL place in shared package multdiv_pkg: the FSM state enum, the WIDTH default (32) and the iteration-count constant.
REQ-026 SHALL instantiate sub-module negate32 (two's-complement negate: invert plus 1) twice for operand magnitudes and once for quotient sign correction.
REQ-027 SHALL contain no multiplier and no division operator; the datapath is subtract/shift only.

Verification
REQ-028 Scenario: A=100, B=7, pulse ctrl_div at C -> data_result=14, data_exception=0, data_resultRDY=1 at C+33 only.
REQ-029 Scenario: A=-100 (0xFFFFFF9C), B=7 -> data_result=0xFFFFFFF2 at C+33; A=-100, B=-7 -> data_result=14.
REQ-030 Scenario: A=5, B=0 -> data_exception=1, data_result=0, RDY at C+1; no RDY at C+33.
REQ-031 Scenario: A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=0 at C+33; A=0x80000000, B=2 -> data_result=0xC0000000.
REQ-032 Scenario: start 100/7 at C, then restart 81/9 at C+10 -> exactly one RDY, at C+43, with data_result=9.
REQ-033 Scenario: start 100/7, assert reset_n=0 at C+15 for 2 cycles -> outputs go to 0 immediately and no RDY follows; a subsequent 50/5 yields 10 at +33.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide blocks.
//   DIV_WIDTH  : default operand/result width
//   DIV_ITERS  : quotient bits produced per division (one per cycle)
//   CNT_W      : width of the iteration counter
//   div_state_t: divider control states
package multdiv_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/negate32.sv
// Two's-complement negate (invert plus one).
//   a : input operand
//   y : -a, wrapping (the most negative value maps to itself)
module negate32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = ~a + WIDTH'(1);

endmodule

// File: rtl/div_iter.sv
// Iterative signed divider: restoring division, one quotient bit per cycle.
// Quotient truncates toward zero; the remainder is discarded.
//   clock          : rising-edge clock
//   reset_n        : asynchronous active-low reset (release synchronised)
//   ctrl_div       : start pulse, operands captured on this edge; also restarts
//                    an operation in progress
//   data_operandA  : signed dividend
//   data_operandB  : signed divisor
//   data_result    : signed quotient, held until the next RDY
//   data_exception : divide-by-zero flag, cleared on the next start
//   data_resultRDY : one-cycle pulse marking a valid result
module div_iter
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int unsigned ITERS = WIDTH;

  // Reset asserts asynchronously but releases two clocks later, in step with clock.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             sign;
  logic             dz_pend;

  logic [WIDTH-1:0] neg_a, neg_b, neg_q;
  logic [WIDTH-1:0] mag_a, mag_b;

  negate32 #(.WIDTH(WIDTH)) u_neg_a (.a(data_operandA), .y(neg_a));
  negate32 #(.WIDTH(WIDTH)) u_neg_b (.a(data_operandB), .y(neg_b));
  negate32 #(.WIDTH(WIDTH)) u_neg_q (.a(quo),           .y(neg_q));

  // Magnitude of the most negative value is its own bit pattern, read unsigned.
  assign mag_a = data_operandA[WIDTH-1] ? neg_a : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? neg_b : data_operandB;

  // Restoring step: dividend bits shift out of the top of quo into the
  // remainder; quotient bits shift in at the bottom.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {2'b00, divisor};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      divisor        <= '0;
      sign           <= 1'b0;
      dz_pend        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      dz_pend        <= 1'b0;

      // Divide-by-zero reports one cycle after its start edge, FSM stays idle.
      if (dz_pend) begin
        data_result    <= '0;
        data_exception <= 1'b1;
        data_resultRDY <= 1'b1;
      end

      // A start in any state wins, including over FIX->IDLE; an in-flight
      // operation is dropped without a RDY.
      if (ctrl_div) begin
        data_exception <= 1'b0;
        cnt            <= '0;
        rem            <= '0;
        if (data_operandB == '0) begin
          state   <= IDLE;
          dz_pend <= 1'b1;
        end else begin
          state   <= DIV;
          quo     <= mag_a;
          divisor <= mag_b;
          sign    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        end
      end else begin
        unique case (state)
          IDLE: ;
          DIV: begin
            if (!diff[WIDTH+1]) begin
              rem <= diff[WIDTH:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(ITERS - 1)) state <= FIX;
          end
          FIX: begin
            data_result    <= sign ? neg_q : quo;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
